uart_rx_frame_check: RTL and testbench
======================================

Name: uart_rx_frame_check

Overview:
- Parametrised frame checker for the UART receiver.
- Consumes the sampled serial bit stream, one bit per BIT_VLD strobe from the oversampling/sampler stage.
- Tracks frame position itself: start bit, DATA_W data bits, optional parity bit, then one or two stop bits.
- Deserialises data (LSB first) and checks parity in four modes (even/odd/mark/space) and stop bits.
- Reports a one-cycle frame-valid pulse with error flags, and keeps saturating error counters for status readout.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9.
- CNT_W, 8, width of each saturating error counter.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous active-low reset.
- BIT_VLD  input  1  one-cycle strobe: BIT_VAL holds a sampled line bit.
- BIT_VAL  input  1  sampled line value.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  2  00 even, 01 odd, 10 mark, 11 space.
- STOP2  input  1  1 = two stop bits.
- ERR_CLR  input  1  one-cycle pulse; zeroes both error counters.
- P_DATA  output  DATA_W  last received data word.
- DATA_VLD  output  1  one-cycle pulse: frame complete.
- PAR_ERR  output  1  parity error for the frame flagged by DATA_VLD.
- STP_ERR  output  1  stop error for the frame flagged by DATA_VLD.
- BUSY  output  1  frame in progress.
- PAR_ERR_CNT  output  CNT_W  saturating count of parity errors.
- STP_ERR_CNT  output  CNT_W  saturating count of stop errors.

Behaviour:
- Reset (RST=0 at a clock edge) returns the FSM to IDLE and clears every output and internal register to 0, including the counters. This applies mid-frame; the partial frame is discarded with no DATA_VLD.
- FSM states: IDLE, DATA, PARITY, STOP. All state changes occur only on cycles with BIT_VLD=1.
- IDLE:
  - BIT_VAL=1: stay in IDLE (line idle).
  - BIT_VAL=0: start bit accepted. Latch PAR_EN, PAR_TYP and STOP2 into a frame config; clear the bit counter and running parity; set BUSY; go to DATA.
- DATA:
  - Shift BIT_VAL in LSB first and XOR it into the running parity.
  - After the DATA_W-th bit: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: compare BIT_VAL with the expected bit, record the mismatch, go to STOP.
  - even: expected = XOR of data (total ones incl. parity is even).
  - odd: expected = XNOR of data.
  - mark: expected = 1.
  - space: expected = 0.
- STOP:
  - Each stop bit must be 1; any 0 records a stop error.
  - With latched STOP2=1, both stop bits are always consumed, even if the first is 0.
  - After the last stop bit, go to IDLE.
- Frame-end timing: on the clock edge that accepts the last stop bit, all of the following happen together:
  - DATA_VLD=1 for exactly one cycle.
  - P_DATA updates.
  - PAR_ERR and STP_ERR update.
  - BUSY clears.
- P_DATA, PAR_ERR and STP_ERR then hold until the next frame completes. PAR_ERR is 0 when latched PAR_EN=0.
- Config inputs changing mid-frame have no effect until the next start bit.
- Counters:
  - +1 on the DATA_VLD edge when the matching error flag sets.
  - Saturate at all-ones; no wrap.
  - ERR_CLR has priority over a same-cycle increment, so the counter becomes 0 and that event is not counted.
- Back-to-back frames: a start bit may arrive on the very next BIT_VLD after the final stop bit.
- BIT_VLD=0 cycles stall the FSM with no state change and no timeout.

Decomposition:
- Shared package uart_rx_pkg holds:
  - PAR_TYP codes: PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11.
  - FSM state encoding, reused by the sampler FSM.
- One sub-module: uart_sat_counter. Parameter CNT_W; ports CLK, RST, CLR, INC, CNT. Instantiated twice.

Test Plan:
- 0xA5, PAR_EN=1, even. Bits 0,1,0,1,0,0,1,0,1,0(parity),1(stop) -> DATA_VLD pulse, P_DATA=0xA5, PAR_ERR=0, STP_ERR=0, counters 0.
- Same frame with PAR_TYP=odd (parity bit still 0) -> PAR_ERR=1, PAR_ERR_CNT=1. Then a mark frame with parity bit 1 -> PAR_ERR=0, counter stays 1.
- STOP2=1, PAR_EN=0, 0x3C, stop bits 0 then 1 -> both stop bits consumed, STP_ERR=1, STP_ERR_CNT=1, BUSY low after second stop bit.
- DATA_W=7 instance, 0x55, space parity, parity bit 1 -> PAR_ERR=1. Toggling PAR_TYP mid-frame does not change the result.
- CNT_W=2 with 5 parity-error frames -> count goes 1,2,3,3,3. ERR_CLR coincident with a 6th error frame -> count 0.
- RST low after the 4th data bit -> all outputs 0, no DATA_VLD. The next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: parity type codes, FSM state encoding
// and the expected-parity helper used by the frame checker.
package uart_rx_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10,
        STOP   = 2'b11
    } rx_state_t;

    // data_xor is the XOR of all received data bits
    function automatic logic par_expect(input logic [1:0] typ, input logic data_xor);
        logic exp_bit;
        exp_bit = 1'b0;
        case (typ)
            PAR_EVEN:  exp_bit = data_xor;
            PAR_ODD:   exp_bit = ~data_xor;
            PAR_MARK:  exp_bit = 1'b1;
            PAR_SPACE: exp_bit = 1'b0;
            default:   exp_bit = 1'b0;
        endcase
        return exp_bit;
    endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Counts on the same edge INC is sampled high, never wraps.
module uart_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             INC,
    output logic [CNT_W-1:0] CNT
);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            CNT <= '0;
        end else if (CLR) begin
            CNT <= '0;
        end else if (INC && (CNT != {CNT_W{1'b1}})) begin
            CNT <= CNT + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART frame checker: deserialises start/data/parity/stop from sampled bits,
// pulses DATA_VLD with error flags on the edge accepting the last stop bit.
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BIT_VLD,
    input  logic              BIT_VAL,
    input  logic              PAR_EN,
    input  logic [1:0]        PAR_TYP,
    input  logic              STOP2,
    input  logic              ERR_CLR,
    output logic [DATA_W-1:0] P_DATA,
    output logic              DATA_VLD,
    output logic              PAR_ERR,
    output logic              STP_ERR,
    output logic              BUSY,
    output logic [CNT_W-1:0]  PAR_ERR_CNT,
    output logic [CNT_W-1:0]  STP_ERR_CNT
);

    localparam int BCW = $clog2(DATA_W);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [BCW-1:0]    bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              run_par;
    logic              cfg_par_en;
    logic [1:0]        cfg_par_typ;
    logic              cfg_stop2;
    logic              par_bad;
    logic              stop_bad;
    logic              stop_idx;
    logic              frame_done;
    logic              par_err_nxt;
    logic              stp_err_nxt;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_done  = 1'b0;
        par_err_nxt = par_bad;
        stp_err_nxt = stop_bad | ~BIT_VAL;
        if (BIT_VLD) begin
            case (state)
                IDLE: begin
                    if (!BIT_VAL) begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (bit_cnt == BCW'(DATA_W - 1)) begin
                        state_nxt = cfg_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    state_nxt = STOP;
                end
                STOP: begin
                    // second stop bit is consumed even after a bad first one
                    if (!cfg_stop2 || stop_idx) begin
                        state_nxt  = IDLE;
                        frame_done = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            run_par     <= 1'b0;
            cfg_par_en  <= 1'b0;
            cfg_par_typ <= PAR_EVEN;
            cfg_stop2   <= 1'b0;
            par_bad     <= 1'b0;
            stop_bad    <= 1'b0;
            stop_idx    <= 1'b0;
            P_DATA      <= '0;
            DATA_VLD    <= 1'b0;
            PAR_ERR     <= 1'b0;
            STP_ERR     <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            DATA_VLD <= frame_done;
            if (BIT_VLD) begin
                case (state)
                    IDLE: begin
                        if (!BIT_VAL) begin
                            cfg_par_en  <= PAR_EN;
                            cfg_par_typ <= PAR_TYP;
                            cfg_stop2   <= STOP2;
                            bit_cnt     <= '0;
                            run_par     <= 1'b0;
                            par_bad     <= 1'b0;
                            stop_bad    <= 1'b0;
                            stop_idx    <= 1'b0;
                            BUSY        <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {BIT_VAL, shreg[DATA_W-1:1]};
                        run_par <= run_par ^ BIT_VAL;
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                    PARITY: begin
                        par_bad <= (BIT_VAL != par_expect(cfg_par_typ, run_par));
                    end
                    STOP: begin
                        stop_bad <= stp_err_nxt;
                        stop_idx <= 1'b1;
                    end
                    default: begin
                        stop_idx <= 1'b0;
                    end
                endcase
            end
            if (frame_done) begin
                P_DATA  <= shreg;
                PAR_ERR <= par_err_nxt;
                STP_ERR <= stp_err_nxt;
                BUSY    <= 1'b0;
            end
        end
    end

    uart_sat_counter #(.CNT_W(CNT_W)) u_par_cnt (
        .CLK (CLK),
        .RST (RST),
        .CLR (ERR_CLR),
        .INC (frame_done & par_err_nxt),
        .CNT (PAR_ERR_CNT)
    );

    uart_sat_counter #(.CNT_W(CNT_W)) u_stp_cnt (
        .CLK (CLK),
        .RST (RST),
        .CLR (ERR_CLR),
        .INC (frame_done & stp_err_nxt),
        .CNT (STP_ERR_CNT)
    );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: an 8-bit/8-bit-counter instance and a
// 7-bit/2-bit-counter instance driven with directed frames.
module tb_uart_rx_frame_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       bvld[2];
    logic       bval[2];
    logic       paren[2];
    logic [1:0] ptyp[2];
    logic       stop2[2];
    logic       eclr[2];

    logic [7:0] pd0, pc0, sc0;
    logic [6:0] pd1;
    logic [1:0] pc1, sc1;
    logic       dv0, pe0, se0, busy0;
    logic       dv1, pe1, se1, busy1;

    logic [31:0] a_data[2], a_pc[2], a_sc[2];
    logic        a_dv[2], a_pe[2], a_se[2], a_busy[2];

    // frame-level model of what the outputs must be after each edge
    bit m_vld[2], m_busy[2], m_perr[2], m_serr[2];
    int m_data[2], m_pc[2], m_sc[2];
    int cmax[2] = '{255, 3};
    int dw[2]   = '{8, 7};
    bit chk_en  = 1'b0;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_rx_frame_check #(.DATA_W(8), .CNT_W(8)) u_dut8 (
        .CLK(clk), .RST(rst), .BIT_VLD(bvld[0]), .BIT_VAL(bval[0]),
        .PAR_EN(paren[0]), .PAR_TYP(ptyp[0]), .STOP2(stop2[0]), .ERR_CLR(eclr[0]),
        .P_DATA(pd0), .DATA_VLD(dv0), .PAR_ERR(pe0), .STP_ERR(se0), .BUSY(busy0),
        .PAR_ERR_CNT(pc0), .STP_ERR_CNT(sc0)
    );

    uart_rx_frame_check #(.DATA_W(7), .CNT_W(2)) u_dut7 (
        .CLK(clk), .RST(rst), .BIT_VLD(bvld[1]), .BIT_VAL(bval[1]),
        .PAR_EN(paren[1]), .PAR_TYP(ptyp[1]), .STOP2(stop2[1]), .ERR_CLR(eclr[1]),
        .P_DATA(pd1), .DATA_VLD(dv1), .PAR_ERR(pe1), .STP_ERR(se1), .BUSY(busy1),
        .PAR_ERR_CNT(pc1), .STP_ERR_CNT(sc1)
    );

    always_comb begin
        a_data[0] = 32'(pd0);  a_data[1] = 32'(pd1);
        a_pc[0]   = 32'(pc0);  a_pc[1]   = 32'(pc1);
        a_sc[0]   = 32'(sc0);  a_sc[1]   = 32'(sc1);
        a_dv[0]   = dv0;       a_dv[1]   = dv1;
        a_pe[0]   = pe0;       a_pe[1]   = pe1;
        a_se[0]   = se0;       a_se[1]   = se1;
        a_busy[0] = busy0;     a_busy[1] = busy1;
    end

    task automatic check(input string nm, input int act, input int want);
        n_tot++;
        if (act != want) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, want, $time);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("data_vld[%0d]", k), int'(a_dv[k]), int'(m_vld[k]));
                    check($sformatf("busy[%0d]", k), int'(a_busy[k]), int'(m_busy[k]));
                    check($sformatf("p_data[%0d]", k), int'(a_data[k]), m_data[k]);
                    check($sformatf("par_err[%0d]", k), int'(a_pe[k]), int'(m_perr[k]));
                    check($sformatf("stp_err[%0d]", k), int'(a_se[k]), int'(m_serr[k]));
                    check($sformatf("par_cnt[%0d]", k), int'(a_pc[k]), m_pc[k]);
                    check($sformatf("stp_cnt[%0d]", k), int'(a_sc[k]), m_sc[k]);
                end
            end
        end
    end

    // advance to the next falling edge with all strobes idle
    task automatic step_begin();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bvld[k]  = 1'b0;
            eclr[k]  = 1'b0;
            m_vld[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        step_begin();
        rst    = 1'b0;
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_perr[k] = 1'b0; m_serr[k] = 1'b0;
            m_data[k] = 0;    m_pc[k]   = 0;    m_sc[k]   = 0;
        end
        step_begin();
        rst = 1'b1;
    endtask

    task automatic idle_bits(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            step_begin();
            bvld[k] = 1'b1;
            bval[k] = 1'b1;
        end
    endtask

    task automatic send_frame(input int k, input int data, input bit pen, input logic [1:0] pt,
                              input bit s2, input bit parbit, input bit sa, input bit sb,
                              input int gap, input bit scr, input bit clr_end);
        bit bits[$];
        int ones;
        bit exp_par, perr, serr, last;
        int dmask;
        dmask = (1 << dw[k]) - 1;
        ones  = $countones(data & dmask);
        case (pt)
            2'b00:   exp_par = (ones % 2) == 1;
            2'b01:   exp_par = (ones % 2) == 0;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
        perr = pen && (parbit != exp_par);
        serr = !sa || (s2 && !sb);
        bits.push_back(1'b0);
        for (int i = 0; i < dw[k]; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(parbit);
        bits.push_back(sa);
        if (s2) bits.push_back(sb);
        for (int i = 0; i < bits.size(); i++) begin
            step_begin();
            if (i == 0) begin
                paren[k] = pen; ptyp[k] = pt; stop2[k] = s2;
            end else if (scr) begin
                paren[k] = !pen; ptyp[k] = pt ^ 2'b01; stop2[k] = !s2;
            end
            bvld[k]   = 1'b1;
            bval[k]   = bits[i];
            last      = (i == bits.size() - 1);
            m_busy[k] = !last;
            if (last) begin
                m_vld[k]  = 1'b1;
                m_data[k] = data & dmask;
                m_perr[k] = perr;
                m_serr[k] = serr;
                if (clr_end) begin
                    eclr[k] = 1'b1;
                    m_pc[k] = 0;
                    m_sc[k] = 0;
                end else begin
                    if (perr && m_pc[k] < cmax[k]) m_pc[k]++;
                    if (serr && m_sc[k] < cmax[k]) m_sc[k]++;
                end
            end
            for (int g = 0; g < gap; g++) step_begin();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int sat_want[5] = '{1, 2, 3, 3, 3};
        logic [3:0] partial = 4'b1101;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bvld[k] = 1'b0; bval[k] = 1'b1; paren[k] = 1'b0;
            ptyp[k] = 2'b00; stop2[k] = 1'b0; eclr[k] = 1'b0;
        end
        do_reset();
        step_begin();
        check("reset p_data", int'(pd0), 0);
        check("reset busy", int'(busy0), 0);
        check("reset par_cnt", int'(pc0), 0);

        idle_bits(0, 3);
        send_frame(0, 'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        step_begin();
        check("a5 even p_data", int'(pd0), 'hA5);
        check("a5 even par_err", int'(pe0), 0);
        check("a5 even stp_err", int'(se0), 0);
        check("a5 even cnt", int'(pc0) + int'(sc0), 0);

        send_frame(0, 'hA5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_frame(0, 'hA5, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        step_begin();
        check("mark par_err", int'(pe0), 0);
        check("odd then mark par_cnt", int'(pc0), 1);

        send_frame(0, 'h3C, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        step_begin();
        check("stop2 p_data", int'(pd0), 'h3C);
        check("stop2 stp_err", int'(se0), 1);
        check("stop2 stp_cnt", int'(sc0), 1);
        check("stop2 busy", int'(busy0), 0);

        send_frame(1, 'h55, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        step_begin();
        check("w7 space p_data", int'(pd1), 'h55);
        check("w7 space par_err", int'(pe1), 1);

        step_begin();
        eclr[1] = 1'b1;
        m_pc[1] = 0;
        m_sc[1] = 0;
        for (int n = 0; n < 5; n++) begin
            send_frame(1, 'h01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, n % 2, 1'b0, 1'b0);
            step_begin();
            check($sformatf("sat par_cnt #%0d", n + 1), int'(pc1), sat_want[n]);
        end
        send_frame(1, 'h01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        step_begin();
        check("clr beats inc par_cnt", int'(pc1), 0);

        step_begin();
        bvld[0] = 1'b1; bval[0] = 1'b0; m_busy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_begin();
            bvld[0] = 1'b1; bval[0] = partial[i];
        end
        do_reset();
        step_begin();
        check("midreset busy", int'(busy0), 0);
        check("midreset p_data", int'(pd0), 0);
        check("midreset stp_cnt", int'(sc0), 0);

        send_frame(0, 'h81, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        step_begin();
        check("after reset p_data", int'(pd0), 'h81);
        check("after reset errs", int'(pe0) + int'(se0), 0);

        repeat (3) step_begin();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
